burger_plate: RTL and testbench
===============================

// Module: burger_plate
// PURPOSE
//   Catching end of the ingredient-fall path. Each falling ingredient raises a landing
//   request on reaching its target. The plate accepts requests one at a time and
//   stacks the ingredients. It publishes the rest Y for the next lander, emits score
//   increments, and flags a completed burger. One instance per plate column.
// PARAMETERS
//   N_ING           4     ingredients that complete one burger (1..7)
//   PLATE_Y         468   rest Y of the first layer, in doubled screen coords
//   LAYER_H         8     Y step per stacked layer, in doubled coords
//   SCORE_PER_LAYER 50    points added per accepted landing
//   COMPLETE_BONUS  500   extra points added on the landing that completes the burger
// PORTS
//   frame_clk   in   1      frame clock; all state changes on rising edge
//   Reset       in   1      asynchronous, active-high; forces the reset state below
//   clear       in   1      synchronous restart for a new level; same effect as Reset
//   land_req    in   N_ING  level per ingredient; held high until acked (its finish)
//   land_ack    out  N_ING  one-hot, one-cycle acceptance pulse
//   next_rest_y out  10     PLATE_Y - layer_count*LAYER_H
//   layer_count out  3      layers accepted so far (0..N_ING)
//   score_add   out  16     points for this event; valid only with score_valid
//   score_valid out  1      one-cycle pulse
//   complete    out  1      high once layer_count==N_ING; held until Reset/clear
// BEHAVIOUR
//   Reset/clear: state=IDLE; land_ack=0; served mask=0; layer_count=0;
//     next_rest_y=PLATE_Y; score_add=0; score_valid=0; complete=0.
//   served[i] is set when land_ack[i] fires. A request from a served ingredient is
//     ignored until Reset/clear, so a level-held finish is never counted twice.
//   Eligible set = land_req & ~served. Arbitration: fixed priority, lowest index wins.
//   FSM states: IDLE, ACK, SCORE, COMPLETE.
//     IDLE: eligible!=0 and layer_count<N_ING -> ACK, latching the winner index.
//     ACK (1 cycle):
//       land_ack[winner]=1; served[winner] set; layer_count += 1.
//       next_rest_y is updated from the new layer_count on the same edge.
//       Go to SCORE.
//     SCORE (1 cycle): score_valid=1.
//       score_add = SCORE_PER_LAYER, plus COMPLETE_BONUS if layer_count==N_ING.
//       Go to COMPLETE if layer_count==N_ING, else go to IDLE.
//     COMPLETE: complete=1. Every land_req is ignored. Exit only by Reset/clear.
//   Latency: an eligible req sampled in IDLE at edge k gives land_ack at k+1 and
//     score_valid at k+2. Earliest next acceptance is at k+3.
//     The throughput is therefore one landing per 3 frames.
//   Simultaneous requests: served in index order, one per 3-cycle round.
//     Losers stay pending; they are not dropped.
//   A request that is deasserted before it is acked is simply not served (no latch).
//   Arithmetic: 10-bit unsigned next_rest_y. Parameters guarantee
//     N_ING*LAYER_H <= PLATE_Y, so next_rest_y never wraps.
//     score_add saturates at 16'hFFFF.
//   Reset/clear mid-operation: abandon ACK/SCORE immediately.
//     Any pending land_ack or score_valid never appears.
//   Outputs are registered. No combinational path from land_req to land_ack.
// TESTING
//   1 Reset, then land_req=4'b0001 held -> land_ack=0001 one cycle later;
//       score_valid next cycle with score_add=50; layer_count=1; next_rest_y=460;
//       no second ack while req stays high.
//   2 land_req=4'b1010 in one cycle -> ack 0010 first, then ack 1000 three cycles
//       later; layer_count=2; next_rest_y=452.
//   3 Four landings accepted -> 4th score_add=550; complete=1; next_rest_y=436;
//       a further land_req=1111 produces no ack and no score.
//   4 Reset asserted between ack and score_valid -> no score_valid pulse;
//       all outputs at reset values; the same ingredient is re-ackable afterwards.
//   5 land_req[2] pulsed high then low before winning arbitration (req[0] active)
//       -> only ingredient 0 is acked; layer_count=1.
//   6 clear while complete=1 -> next edge complete=0, layer_count=0,
//       next_rest_y=468; the following req is acked normally.

Source files
------------

// File: rtl/burger_plate.sv
// Landing arbiter and layer stack for one plate column: accepts one falling
// ingredient per 3-frame round, tracks stack height and emits score events.
module burger_plate #(
    parameter int unsigned N_ING           = 4,
    parameter int unsigned PLATE_Y         = 468,
    parameter int unsigned LAYER_H         = 8,
    parameter int unsigned SCORE_PER_LAYER = 50,
    parameter int unsigned COMPLETE_BONUS  = 500
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic [N_ING-1:0] land_req,
    output logic [N_ING-1:0] land_ack,
    output logic [9:0]       next_rest_y,
    output logic [2:0]       layer_count,
    output logic [15:0]      score_add,
    output logic             score_valid,
    output logic             complete
);

    localparam int unsigned REST_W  = 10;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned SCORE_W = 16;
    localparam int unsigned SUM_W   = 33;

    typedef enum logic [1:0] {IDLE, ACK, SCORE, COMPLETE} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   winner, winner_d, pick;
    logic [N_ING-1:0]   served, served_d, eligible;
    logic [N_ING-1:0]   ack_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [REST_W-1:0]  rest_d;
    logic [SCORE_W-1:0] sa_d;
    logic               sv_d, complete_d, full;
    logic [SUM_W-1:0]   score_sum;

    assign eligible  = land_req & ~served;
    assign full      = (layer_count == CNT_W'(N_ING));
    assign score_sum = SUM_W'(SCORE_PER_LAYER) + (full ? SUM_W'(COMPLETE_BONUS) : SUM_W'(0));

    // Fixed priority: lowest eligible index wins.
    always_comb begin
        pick = '0;
        for (int i = int'(N_ING) - 1; i >= 0; i--) begin
            if (eligible[i]) pick = CNT_W'(i);
        end
    end

    always_comb begin
        state_d    = state;
        winner_d   = winner;
        served_d   = served;
        cnt_d      = layer_count;
        rest_d     = next_rest_y;
        ack_d      = '0;
        sv_d       = 1'b0;
        sa_d       = '0;
        complete_d = complete;

        case (state)
            IDLE: begin
                if (eligible != '0 && layer_count < CNT_W'(N_ING)) begin
                    state_d  = ACK;
                    winner_d = pick;
                end
            end
            ACK: begin
                for (int i = 0; i < int'(N_ING); i++) begin
                    ack_d[i] = (winner == CNT_W'(i));
                end
                served_d = served | ack_d;
                cnt_d    = layer_count + CNT_W'(1);
                rest_d   = REST_W'(PLATE_Y - (32'(layer_count) + 32'd1) * LAYER_H);
                state_d  = SCORE;
            end
            SCORE: begin
                sv_d = 1'b1;
                sa_d = (score_sum > SUM_W'(16'hFFFF)) ? 16'hFFFF : SCORE_W'(score_sum);
                if (full) begin
                    state_d    = COMPLETE;
                    complete_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            COMPLETE: complete_d = 1'b1;
            default:  state_d = IDLE;
        endcase

        // Level restart overrides everything, pending pulses included.
        if (clear) begin
            state_d    = IDLE;
            winner_d   = '0;
            served_d   = '0;
            cnt_d      = '0;
            rest_d     = REST_W'(PLATE_Y);
            ack_d      = '0;
            sv_d       = 1'b0;
            sa_d       = '0;
            complete_d = 1'b0;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            winner      <= '0;
            served      <= '0;
            layer_count <= '0;
            next_rest_y <= REST_W'(PLATE_Y);
            land_ack    <= '0;
            score_valid <= 1'b0;
            score_add   <= '0;
            complete    <= 1'b0;
        end else begin
            state       <= state_d;
            winner      <= winner_d;
            served      <= served_d;
            layer_count <= cnt_d;
            next_rest_y <= rest_d;
            land_ack    <= ack_d;
            score_valid <= sv_d;
            score_add   <= sa_d;
            complete    <= complete_d;
        end
    end

endmodule

// File: tb/tb_burger_plate.sv
// Bench for burger_plate: directed scenarios plus random traffic, checked
// each frame against a timeline model of landings and score events.
module tb_burger_plate;

    localparam int unsigned N     = 4;
    localparam int unsigned PY    = 468;
    localparam int unsigned LH    = 8;
    localparam int unsigned SPL   = 50;
    localparam int unsigned BONUS = 500;

    logic         frame_clk = 1'b0;
    logic         Reset     = 1'b1;
    logic         clear     = 1'b0;
    logic [N-1:0] land_req  = '0;
    logic [N-1:0] land_ack;
    logic [9:0]   next_rest_y;
    logic [2:0]   layer_count;
    logic [15:0]  score_add;
    logic         score_valid;
    logic         complete;

    burger_plate #(
        .N_ING(N), .PLATE_Y(PY), .LAYER_H(LH),
        .SCORE_PER_LAYER(SPL), .COMPLETE_BONUS(BONUS)
    ) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .clear      (clear),
        .land_req   (land_req),
        .land_ack   (land_ack),
        .next_rest_y(next_rest_y),
        .layer_count(layer_count),
        .score_add  (score_add),
        .score_valid(score_valid),
        .complete   (complete)
    );

    always #5 frame_clk = ~frame_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Timeline model: an acceptance at frame c schedules the ack at c+1,
    // the score at c+2 and reopens the plate at c+3.
    int           cyc      = 0;
    logic [N-1:0] m_served = '0;
    int           m_count  = 0;
    bit           m_done   = 1'b0;
    int           free_at  = 0;
    int           ack_at   = -1;
    int           score_at = -1;
    int           m_win    = 0;
    logic [N-1:0] m_ack    = '0;
    bit           m_sv     = 1'b0;
    int           m_sa     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (frame %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] elig;
        m_ack = '0;
        m_sv  = 1'b0;
        m_sa  = 0;
        if (Reset || clear) begin
            m_served = '0;
            m_count  = 0;
            m_done   = 1'b0;
            free_at  = cyc + 1;
            ack_at   = -1;
            score_at = -1;
        end else if (cyc == ack_at) begin
            m_ack    = N'(1 << m_win);
            m_served = m_served | m_ack;
            m_count++;
        end else if (cyc == score_at) begin
            m_sv = 1'b1;
            m_sa = int'(SPL) + ((m_count == int'(N)) ? int'(BONUS) : 0);
            if (m_sa > 65535) m_sa = 65535;
            if (m_count == int'(N)) m_done = 1'b1;
        end else begin
            elig = land_req & ~m_served;
            if (!m_done && cyc >= free_at && m_count < int'(N) && elig != '0) begin
                for (int i = int'(N) - 1; i >= 0; i--) if (elig[i]) m_win = i;
                ack_at   = cyc + 1;
                score_at = cyc + 2;
                free_at  = cyc + 3;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] req, input bit clr = 1'b0, input bit rst = 1'b0);
        @(negedge frame_clk);
        land_req = req;
        clear    = clr;
        Reset    = rst;
        @(posedge frame_clk);
        model_edge();
        #1;
        chk("land_ack", 32'(land_ack), 32'(m_ack));
        chk("score_valid", 32'(score_valid), 32'(m_sv));
        if (m_sv || rst || clr) chk("score_add", 32'(score_add), 32'(m_sa));
        chk("layer_count", 32'(layer_count), 32'(m_count));
        chk("next_rest_y", 32'(next_rest_y), 32'(int'(PY) - m_count * int'(LH)));
        chk("complete", 32'(complete), 32'(m_done));
        cyc++;
    endtask

    initial begin
        // Reset values
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        chk("rst_rest", 32'(next_rest_y), 32'd468);
        chk("rst_cnt", 32'(layer_count), 32'd0);
        chk("rst_sa", 32'(score_add), 32'd0);

        // Single held request: one ack, one score, never re-acked
        step(4'b0001);
        step(4'b0001);
        chk("t1_ack", 32'(land_ack), 32'h1);
        step(4'b0001);
        chk("t1_sv", 32'(score_valid), 32'd1);
        chk("t1_sa", 32'(score_add), 32'd50);
        chk("t1_cnt", 32'(layer_count), 32'd1);
        chk("t1_rest", 32'(next_rest_y), 32'd460);
        repeat (4) step(4'b0001);
        chk("t1_noack", 32'(land_ack), 32'h0);

        // Simultaneous requests served in index order, three frames apart
        step('0, 1'b0, 1'b1);
        step(4'b1010);
        step(4'b1010);
        chk("t2_ack1", 32'(land_ack), 32'h2);
        step(4'b1010);
        step(4'b1010);
        step(4'b1010);
        chk("t2_ack3", 32'(land_ack), 32'h8);
        chk("t2_cnt", 32'(layer_count), 32'd2);
        chk("t2_rest", 32'(next_rest_y), 32'd452);
        step(4'b1010);

        // Complete the burger, then all requests are ignored
        repeat (6) step(4'b0101);
        chk("t3_sa", 32'(score_add), 32'd550);
        chk("t3_complete", 32'(complete), 32'd1);
        chk("t3_rest", 32'(next_rest_y), 32'd436);
        repeat (6) step(4'b1111);
        chk("t3_noack", 32'(land_ack), 32'h0);
        chk("t3_nosv", 32'(score_valid), 32'd0);

        // clear while complete restarts the level
        step('0, 1'b1);
        chk("t6_complete", 32'(complete), 32'd0);
        chk("t6_cnt", 32'(layer_count), 32'd0);
        chk("t6_rest", 32'(next_rest_y), 32'd468);
        step(4'b0001);
        step(4'b0001);
        chk("t6_ack", 32'(land_ack), 32'h1);
        step(4'b0001);

        // Reset between ack and score drops the score and forgets the ack
        step('0, 1'b1);
        step(4'b0001);
        step(4'b0001);
        chk("t4_ack", 32'(land_ack), 32'h1);
        step(4'b0001, 1'b0, 1'b1);
        chk("t4_nosv", 32'(score_valid), 32'd0);
        chk("t4_cnt", 32'(layer_count), 32'd0);
        step(4'b0001);
        step(4'b0001);
        chk("t4_reack", 32'(land_ack), 32'h1);
        step(4'b0001);

        // Request withdrawn before winning is not served
        step('0, 1'b1);
        step(4'b0101);
        step(4'b0001);
        step(4'b0001);
        repeat (4) step(4'b0001);
        chk("t5_cnt", 32'(layer_count), 32'd1);

        // Random traffic with occasional clear and reset
        repeat (400) begin
            step(N'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
